// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipeline_ctrl_pkg;

    // Sequencer state width and encoding
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

    // Default memory-wait timeout (consecutive frozen cycles) and counter width
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 32;

    // Wait counter is wide enough for the largest legal TIMEOUT (255)
    localparam int WAIT_W = 8;

    // Per-cycle control bundle driven to the PC and pipeline registers
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } pipe_ctl_t;

    // Every register frozen, nothing flushed
    localparam pipe_ctl_t CTL_FREEZE = '{default: 1'b0};

    // Normal advance: every register written, nothing flushed
    localparam pipe_ctl_t CTL_RUN = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        id_ex_write:  1'b1,
        ex_mem_write: 1'b1,
        mem_wb_write: 1'b1,
        flush_if_id:  1'b0,
        flush_id_ex:  1'b0,
        flush_ex_mem: 1'b0
    };

    // Reset image: registers held, all stages cleared to bubbles
    localparam pipe_ctl_t CTL_RESET = '{
        pc_write:     1'b0,
        if_id_write:  1'b0,
        id_ex_write:  1'b0,
        ex_mem_write: 1'b0,
        mem_wb_write: 1'b0,
        flush_if_id:  1'b1,
        flush_id_ex:  1'b1,
        flush_ex_mem: 1'b1
    };

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: counts increment strobes, sticks at all-ones.
// Latency: count visible one cycle after the strobe.
// Backpressure: none; increments are dropped once saturated.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic         at_max;

    assign at_max = (cnt_q == {W{1'b1}});

    // Synchronous clear wins; otherwise count up until all-ones
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_max) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, MEM branch and dmem wait.
// Latency: control outputs are combinational from state + inputs (same-cycle stall).
// Backpressure: a pending data-memory access freezes every stage until dmem_ready.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_hazard,
    input  logic             branch_taken_MEM,
    input  logic             mem_access_MEM,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             mem_trap,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_nxt;

    pipe_ctl_t ctl;
    logic      req;
    logic      trap;
    logic      release_hz;
    logic      stall_inc;
    logic      flush_inc;
    logic      wait_inc;

    // Number of frozen cycles including the current one
    assign wait_nxt = wait_q + WAIT_W'(1);

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and same-cycle control decode
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ctl        = CTL_FREEZE;
        req        = 1'b0;
        trap       = 1'b0;
        release_hz = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        wait_inc   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_access_MEM) begin
                    req = 1'b1;
                    if (dmem_ready) begin
                        release_hz = 1'b1;
                    end else begin
                        // First frozen cycle of a multi-cycle access
                        wait_inc = 1'b1;
                        wait_d   = WAIT_W'(1);
                        state_d  = ST_MEM_WAIT;
                    end
                end else begin
                    release_hz = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                req = 1'b1;
                if (dmem_ready) begin
                    // Hazards sampled during the freeze are re-evaluated now
                    release_hz = 1'b1;
                    wait_d     = '0;
                    state_d    = ST_RUN;
                end else begin
                    wait_inc = 1'b1;
                    if (wait_nxt == TIMEOUT_V) begin
                        // TIMEOUT consecutive frozen cycles without completion
                        wait_d  = '0;
                        state_d = ST_TRAP;
                    end else begin
                        wait_d = wait_nxt;
                    end
                end
            end

            ST_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase

        // Branch flush outranks the load-use bubble
        if (release_hz) begin
            if (branch_taken_MEM) begin
                ctl              = CTL_RUN;
                ctl.flush_if_id  = 1'b1;
                ctl.flush_id_ex  = 1'b1;
                ctl.flush_ex_mem = 1'b1;
                flush_inc        = 1'b1;
            end else if (load_use_hazard) begin
                ctl             = CTL_RUN;
                ctl.pc_write    = 1'b0;
                ctl.if_id_write = 1'b0;
                ctl.flush_id_ex = 1'b1;
                stall_inc       = 1'b1;
            end else begin
                ctl = CTL_RUN;
            end
        end

        // Reset overrides everything, including the memory request
        if (rst) begin
            ctl       = CTL_RESET;
            req       = 1'b0;
            trap      = 1'b0;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
            wait_inc  = 1'b0;
            state_d   = ST_RUN;
            wait_d    = '0;
        end
    end

    assign dmem_req     = req;
    assign mem_trap     = trap;
    assign pc_write     = ctl.pc_write;
    assign IF_ID_write  = ctl.if_id_write;
    assign ID_EX_write  = ctl.id_ex_write;
    assign EX_MEM_write = ctl.ex_mem_write;
    assign MEM_WB_write = ctl.mem_wb_write;
    assign flush_IF_ID  = ctl.flush_if_id;
    assign flush_ID_EX  = ctl.flush_id_ex;
    assign flush_EX_MEM = ctl.flush_ex_mem;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (wait_inc),
        .cnt_o (memwait_cnt)
    );

endmodule
